// File: rtl/alu_acc_seq.sv
// Accumulator sequencer in front of a combinational ALU: buffers {load, opcode, operand}
// instructions in a FIFO, feeds the ALU from acc/head, and returns results over valid/ready.
module alu_acc_seq #(
  parameter int WIDTH = 8,
  parameter int OPW   = 3,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPW-1:0]           in_opcode,
  input  logic [WIDTH-1:0]         in_operand,
  input  logic                     in_load,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [OPW-1:0]           alu_opcode,
  input  logic [WIDTH-1:0]         alu_out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH-1:0]         res_data,
  output logic [WIDTH-1:0]         acc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = WIDTH + OPW + 1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t            state, state_nxt;
  logic [EW-1:0]     mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [EW-1:0]     head;
  logic              head_load;
  logic [OPW-1:0]    head_op;
  logic [WIDTH-1:0]  head_operand;
  logic              not_empty;
  logic              push;
  logic              exec;
  logic [WIDTH-1:0]  result;

  assign head         = mem[rd_ptr];
  assign head_load    = head[EW-1];
  assign head_op      = head[WIDTH +: OPW];
  assign head_operand = head[WIDTH-1:0];

  assign not_empty = (count != '0);
  // A full FIFO refuses pushes even when the head is leaving this cycle.
  assign in_ready  = (count < CW'(DEPTH));
  assign push      = in_valid && in_ready;
  assign exec      = not_empty && (state == IDLE || res_ready);

  assign alu_a      = acc;
  assign alu_b      = not_empty ? head_operand : '0;
  assign alu_opcode = not_empty ? head_op : '0;
  assign result     = head_load ? head_operand : alu_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (exec)
      state_nxt = HOLD;
    else if (state == HOLD && res_ready && !not_empty)
      state_nxt = IDLE;
  end

  always_comb begin
    res_valid = (state == HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      res_data <= '0;
    end else if (exec) begin
      acc      <= result;
      res_data <= result;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {in_load, in_opcode, in_operand};
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (exec) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({push, exec})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
